// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: WIDTH-bit operands, registered result and flags,
// valid/ready on both sides, iterative shift-add multiply. One operation in flight.
module alu_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH) + 1;
  localparam int unsigned PW  = 2 * WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_ROTL = 4'd10;
  localparam logic [3:0] OP_ROTR = 4'd11;
  localparam logic [3:0] OP_EQ   = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             res_c_q;
  logic             res_v_q;

  logic [WIDTH-1:0] alu_out;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SHW-1:0]   shamt;
  logic [PW-1:0]    acc_step;

  // Single-cycle operations on the latched operands
  always_comb begin
    alu_out = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    add_w   = {1'b0, a_q} + {1'b0, b_q};
    sub_w   = {1'b0, a_q} - {1'b0, b_q};
    shamt   = b_q[SHW-1:0];
    case (op_q)
      OP_ADD: begin
        alu_out = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_out = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  alu_out = a_q & b_q;
      OP_OR:   alu_out = a_q | b_q;
      OP_NOT:  alu_out = ~a_q;
      OP_XOR:  alu_out = a_q ^ b_q;
      OP_NOR:  alu_out = ~(a_q | b_q);
      OP_SLL:  alu_out = a_q << shamt;
      OP_SRL:  alu_out = a_q >> shamt;
      OP_SRA:  alu_out = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      OP_ROTL: alu_out = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
      OP_ROTR: alu_out = {a_q[0], a_q[WIDTH-1:1]};
      OP_EQ:   alu_out = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
      default: alu_out = '0;
    endcase
  end

  // One multiplier bit per cycle: conditionally add the shifted multiplicand
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Control FSM; the result is published one edge after DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_c_q   <= 1'b0;
      res_v_q   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q     <= ctrl;
            a_q      <= x;
            b_q      <= y;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if ((ctrl == OP_MUL) && (MUL_EN != 0)) begin
              acc_q    <= '0;
              mcand_q  <= PW'(x);
              mplier_q <= y;
              cnt_q    <= '0;
              state    <= S_MUL;
            end else begin
              state    <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          res_q   <= alu_out;
          res_c_q <= alu_c;
          res_v_q <= alu_v;
          state   <= S_DONE;
        end
        S_MUL: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            res_q   <= acc_step[WIDTH-1:0];
            res_c_q <= |acc_step[PW-1:WIDTH];
            res_v_q <= 1'b0;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (!out_valid) begin
            out       <= res_q;
            carry     <= res_c_q;
            overflow  <= res_v_q;
            zero      <= (res_q == '0);
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, handshake/hold/reset scenarios,
// and randomized operations against an integer-arithmetic reference model.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ctrl;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        busy;

  logic        in_valid16;
  logic        in_ready16;
  logic [3:0]  ctrl16;
  logic [15:0] x16;
  logic [15:0] y16;
  logic        out_valid16;
  logic        out_ready16;
  logic [15:0] out16;
  logic        carry16;
  logic        overflow16;
  logic        zero16;
  logic        busy16;

  int pass_cnt;
  int total_cnt;

  alu_seq #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .carry(carry), .overflow(overflow), .zero(zero), .busy(busy)
  );

  alu_seq #(.WIDTH(16), .MUL_EN(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .ctrl(ctrl16),
    .x(x16), .y(y16), .out_valid(out_valid16), .out_ready(out_ready16), .out(out16),
    .carry(carry16), .overflow(overflow16), .zero(zero16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {overflow, carry, out} from plain integer arithmetic
  function automatic logic [9:0] ref_alu(input int op, input int a, input int b);
    int r, c, v, sa, sb, s;
    logic [7:0] rb;
    r = 0; c = 0; v = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127 || s < -128); end
      1: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127 || s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = ~a;
      5: r = a ^ b;
      6: r = ~(a | b);
      7: r = a << (b % 8);
      8: r = a >> (b % 8);
      9: r = sa >>> 1;
      10: r = (a << 1) | (a >> 7);
      11: r = (a >> 1) | (a << 7);
      12: r = (a == b) ? 1 : 0;
      13: begin r = a * b; c = (r > 255); end
      default: r = 0;
    endcase
    rb = r[7:0];
    return {v != 0, c != 0, rb};
  endfunction

  // Present one operation at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1; ctrl = op; x = a; y = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid; records whether in_ready rose meanwhile
  task automatic wait_result(output int k, output bit saw_ready);
    k = 0;
    saw_ready = 1'b0;
    while (!out_valid && k < 40) begin
      if (in_ready) saw_ready = 1'b1;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({out_valid, busy, out, carry, overflow, zero} !== 12'h000) begin
      $display("FAIL reset_state got ov=%b busy=%b out=%h c=%b v=%b z=%b want all 0",
               out_valid, busy, out, carry, overflow, zero);
    end else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_release in_ready=%b busy=%b want 1 0", in_ready, busy);
    end else pass_cnt++;
    // mid-cycle async reset with a nonzero result sitting in DONE
    begin
      int k; bit sr;
      issue(4'd0, 8'h01, 8'h02);
      wait_result(k, sr);
      total_cnt++;
      if (out !== 8'h03 || out_valid !== 1'b1) begin
        $display("FAIL pre_reset_add out=%h valid=%b want 03 1", out, out_valid);
      end else pass_cnt++;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out !== 8'h00) begin
        $display("FAIL async_reset valid=%b busy=%b out=%h want 0 0 00", out_valid, busy, out);
      end else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL async_reset_ready got %b want 1", in_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_arith();
    logic [3:0] ops [7] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd12, 4'd12, 4'd14};
    logic [7:0] as  [7] = '{8'hFF, 8'h7F, 8'h0E, 8'h03, 8'hB3, 8'hB3, 8'h5A};
    logic [7:0] bs  [7] = '{8'h01, 8'h7F, 8'h07, 8'h05, 8'hB3, 8'hA3, 8'hC3};
    logic [7:0] eo  [7] = '{8'h00, 8'hFE, 8'h07, 8'hFE, 8'h01, 8'h00, 8'h00};
    logic       ec  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       ev  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      int k; bit sr;
      issue(ops[i], as[i], bs[i]);
      wait_result(k, sr);
      total_cnt++;
      if (k != 2 || out !== eo[i] || carry !== ec[i] || overflow !== ev[i] || zero !== (eo[i] == 8'h00)) begin
        $display("FAIL arith[%0d] op=%0d lat=%0d out=%h c=%b v=%b z=%b want lat=2 out=%h c=%b v=%b z=%b",
                 i, ops[i], k, out, carry, overflow, zero, eo[i], ec[i], ev[i], eo[i] == 8'h00);
      end else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_shift();
    logic [3:0] ops [5] = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
    logic [7:0] as  [5] = '{8'hF3, 8'hB3, 8'hB3, 8'hB3, 8'hB3};
    logic [7:0] bs  [5] = '{8'hF3, 8'h04, 8'h00, 8'h00, 8'h00};
    logic [7:0] eo  [5] = '{8'h98, 8'h0B, 8'hD9, 8'h67, 8'hD9};
    for (int i = 0; i < 5; i++) begin
      int k; bit sr;
      issue(ops[i], as[i], bs[i]);
      wait_result(k, sr);
      total_cnt++;
      if (k != 2 || out !== eo[i] || carry !== 1'b0 || overflow !== 1'b0) begin
        $display("FAIL shift[%0d] op=%0d lat=%0d out=%h c=%b v=%b want lat=2 out=%h c=0 v=0",
                 i, ops[i], k, out, carry, overflow, eo[i]);
      end else pass_cnt++;
      consume();
    end
    // shift amount zero leaves x unchanged
    begin
      int k; bit sr;
      issue(4'd7, 8'hA5, 8'h08);
      wait_result(k, sr);
      total_cnt++;
      if (out !== 8'hA5) $display("FAIL sll_amt0 out=%h want a5", out);
      else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_mul();
    logic [7:0] as [3] = '{8'h0D, 8'h14, 8'h00};
    logic [7:0] bs [3] = '{8'h0B, 8'h14, 8'hFF};
    logic [7:0] eo [3] = '{8'h8F, 8'h90, 8'h00};
    logic       ec [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      int k; bit sr;
      issue(4'd13, as[i], bs[i]);
      wait_result(k, sr);
      total_cnt++;
      if (k != 9 || sr || out !== eo[i] || carry !== ec[i] || zero !== (eo[i] == 8'h00)) begin
        $display("FAIL mul[%0d] lat=%0d ready_seen=%b out=%h c=%b z=%b want lat=9 ready_seen=0 out=%h c=%b",
                 i, k, sr, out, carry, zero, eo[i], ec[i]);
      end else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_hold();
    int k; bit sr;
    logic [7:0] held;
    bit bad;
    issue(4'd5, 8'h3C, 8'h0F);
    wait_result(k, sr);
    held = out;
    bad = 1'b0;
    in_valid = 1'b1; ctrl = 4'd0; x = 8'h11; y = 8'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (held !== 8'h33 || bad) $display("FAIL hold_done first=%h unstable=%b want 33 0", held, bad);
    else pass_cnt++;
    consume();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 8'h33)
      $display("FAIL hold_release valid=%b ready=%b out=%h want 0 1 33", out_valid, in_ready, out);
    else pass_cnt++;
    // out_ready while idle must not disturb anything
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL idle_out_ready valid=%b busy=%b want 0 0", out_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    issue(4'd13, 8'h0D, 8'h0B);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out !== 8'h00)
      $display("FAIL mid_mul_reset busy=%b valid=%b out=%h want 0 0 00", busy, out_valid, out);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    total_cnt++;
    if (seen || in_ready !== 1'b1) $display("FAIL mid_mul_abort activity=%b ready=%b want 0 1", seen, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int k; bit sr;
    @(negedge clk);
    in_valid = 1'b1; ctrl = 4'd0; x = 8'h10; y = 8'h20;
    @(negedge clk);
    ctrl = 4'd5; x = 8'hF0; y = 8'h0F;
    wait_result(k, sr);
    total_cnt++;
    if (k != 2 || out !== 8'h30 || in_ready !== 1'b0)
      $display("FAIL b2b_first lat=%0d out=%h ready=%b want 2 30 0", k, out, in_ready);
    else pass_cnt++;
    consume();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL b2b_idle ready=%b valid=%b want 1 0", in_ready, out_valid);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(k, sr);
    total_cnt++;
    if (k != 2 || out !== 8'hFF) $display("FAIL b2b_second lat=%0d out=%h want 2 ff", k, out);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int k; bit sr;
      int op, a, b, lat;
      logic [9:0] e;
      op = int'($urandom_range(0, 15));
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      if (i % 8 == 0) b = a;
      e = ref_alu(op, a, b);
      lat = (op == 13) ? 9 : 2;
      issue(4'(op), 8'(a), 8'(b));
      wait_result(k, sr);
      total_cnt++;
      if (k != lat || out !== e[7:0] || carry !== e[8] || overflow !== e[9] || zero !== (e[7:0] == 8'h00)) begin
        $display("FAIL rand[%0d] op=%0d x=%h y=%h lat=%0d out=%h c=%b v=%b z=%b want lat=%0d out=%h c=%b v=%b",
                 i, op, a, b, k, out, carry, overflow, zero, lat, e[7:0], e[8], e[9]);
      end else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_w16_nomul();
    int k;
    @(negedge clk);
    in_valid16 = 1'b1; ctrl16 = 4'd13; x16 = 16'h1234; y16 = 16'h5678;
    @(negedge clk);
    in_valid16 = 1'b0;
    k = 0;
    while (!out_valid16 && k < 40) begin
      @(negedge clk);
      k++;
    end
    total_cnt++;
    if (k != 2 || out16 !== 16'h0000 || carry16 !== 1'b0 || zero16 !== 1'b1)
      $display("FAIL w16_op13 lat=%0d out=%h c=%b z=%b want 2 0000 0 1", k, out16, carry16, zero16);
    else pass_cnt++;
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
    @(negedge clk);
    in_valid16 = 1'b1; ctrl16 = 4'd0; x16 = 16'hFFFF; y16 = 16'h0002;
    @(negedge clk);
    in_valid16 = 1'b0;
    k = 0;
    while (!out_valid16 && k < 40) begin
      @(negedge clk);
      k++;
    end
    total_cnt++;
    if (k != 2 || out16 !== 16'h0001 || carry16 !== 1'b1)
      $display("FAIL w16_add lat=%0d out=%h c=%b want 2 0001 1", k, out16, carry16);
    else pass_cnt++;
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; ctrl = '0; x = '0; y = '0; out_ready = 1'b0;
    in_valid16 = 1'b0; ctrl16 = '0; x16 = '0; y16 = '0; out_ready16 = 1'b0;
    test_reset();
    test_arith();
    test_shift();
    test_mul();
    test_hold();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    test_w16_nomul();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
